matrix_loader: RTL and testbench

//  Write side of the packed-matrix bus consumed by the determinant/arithmetic units.

---
 rtl/matrix_pkg.sv | 15 +
 rtl/matrix_idx_counter.sv | 30 +++
 rtl/matrix_loader.sv | 101 ++++++++++
 tb/tb_matrix_loader.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared matrix-bus definitions: dimensions, loader states and the packed slot layout
// used by the loader and the determinant/operator blocks.
package matrix_pkg;
  localparam int N_MAX    = 5;
  localparam int ELEM_W   = 8;
  localparam int SIZE_MIN = 2;
  localparam int TIMEOUT  = 64;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  // MSB of element (r,c); slot 0 (a11) sits at the top of the packed word.
  function automatic int slot_msb(input int r, input int c, input int n_max, input int w);
    return (n_max*n_max - (r*n_max + c))*w - 1;
  endfunction
endpackage

// File: rtl/matrix_idx_counter.sv
// Row-major (row,col) walker over an n x n sub-square of the packed matrix.
module matrix_idx_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic [2:0] n,
  output logic [2:0] row,
  output logic [2:0] col,
  output logic       last
);
  logic [2:0] n_m1;

  assign n_m1 = n - 3'd1;
  assign last = (row == n_m1) && (col == n_m1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (col == n_m1) begin
        col <= '0;
        row <= row + 3'd1;
      end else begin
        col <= col + 3'd1;
      end
    end
  end
endmodule

// File: rtl/matrix_loader.sv
// Serial element stream -> packed matrix word with valid/ready output handshake.
// Optional MATLOAD_TIMEOUT_EN aborts a load that stalls too long between elements.
module matrix_loader #(
  parameter int N_MAX  = matrix_pkg::N_MAX,
  parameter int ELEM_W = matrix_pkg::ELEM_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [2:0]                size,
  input  logic [ELEM_W-1:0]         elem_in,
  input  logic                      elem_valid,
  output logic                      elem_ready,
  output logic [N_MAX*N_MAX*ELEM_W-1:0] mat_out,
  output logic [2:0]                mat_size,
  output logic                      mat_valid,
  input  logic                      mat_ready,
  output logic                      busy,
  output logic                      err
);
  import matrix_pkg::*;

  state_t     state, state_nx;
  logic [2:0] row, col;
  logic       last, accept, size_ok, load_go, bad_start, tmo;

  assign size_ok   = (size >= 3'(SIZE_MIN)) && (size <= 3'(N_MAX));
  assign load_go   = (state == IDLE) && start && size_ok;
  assign bad_start = (state == IDLE) && start && !size_ok;
  // Decoded from state directly so the FSM block does not read its own output.
  assign accept    = elem_valid && (state == LOAD);
  assign busy      = (state != IDLE);

  matrix_idx_counter u_idx (
    .clk (clk),
    .rst (rst),
    .clr (load_go),
    .inc (accept),
    .n   (mat_size),
    .row (row),
    .col (col),
    .last(last)
  );

`ifdef MATLOAD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;

  // Counts consecutive LOAD cycles with no accepted element; zero on LOAD entry.
  always_ff @(posedge clk) begin
    if (rst || (state != LOAD) || accept) to_cnt <= '0;
    else                                  to_cnt <= to_cnt + TW'(1);
  end

  assign tmo = (state == LOAD) && !accept && (to_cnt == TW'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    elem_ready = 1'b0;
    mat_valid  = 1'b0;
    case (state)
      IDLE: if (load_go) state_nx = LOAD;
      LOAD: begin
        elem_ready = 1'b1;
        if (tmo)                 state_nx = IDLE;
        else if (accept && last) state_nx = DONE;
      end
      DONE: begin
        mat_valid = 1'b1;
        if (mat_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mat_out  <= '0;
      mat_size <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_nx;
      err   <= bad_start || tmo;
      if (load_go) begin
        mat_out  <= '0;
        mat_size <= size;
      end else if (tmo) begin
        mat_out  <= '0;
      end else if (accept) begin
        for (int r = 0; r < N_MAX; r++)
          for (int c = 0; c < N_MAX; c++)
            if (row == 3'(r) && col == 3'(c))
              mat_out[slot_msb(r, c, N_MAX, ELEM_W) -: ELEM_W] <= elem_in;
      end
    end
  end
endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader; completed matrices are checked by a scoreboard monitor.
module tb_matrix_loader;
  localparam int N  = 5;
  localparam int W  = 8;
  localparam int MW = N*N*W;

  logic          clk = 1'b0;
  logic          rst, start, elem_valid, elem_ready, mat_valid, mat_ready, busy, err;
  logic [2:0]    size, mat_size;
  logic [W-1:0]  elem_in;
  logic [MW-1:0] mat_out;

  always #5 clk = ~clk;

  matrix_loader dut (
    .clk(clk), .rst(rst), .start(start), .size(size),
    .elem_in(elem_in), .elem_valid(elem_valid), .elem_ready(elem_ready),
    .mat_out(mat_out), .mat_size(mat_size), .mat_valid(mat_valid),
    .mat_ready(mat_ready), .busy(busy), .err(err)
  );

  typedef struct {
    logic [MW-1:0] mat;
    logic [2:0]    size;
  } exp_t;

  exp_t sbq[$];
  exp_t e_mon;
  int   pass_cnt = 0, chk_cnt = 0, acc_cnt = 0;
  logic mv_prev = 1'b0;

  task automatic chk(input string name, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [MW-1:0] put(input logic [MW-1:0] m, input int k, input logic [W-1:0] v);
    m[(N*N-k)*W-1 -: W] = v;
    return m;
  endfunction

  // Monitor: counts accepted elements, checks each completed matrix against the queue.
  always @(negedge clk) begin
    if (elem_valid && elem_ready) acc_cnt++;
    if (mat_valid && !mv_prev) begin
      if (sbq.size() == 0) chk("unexpected_mat_valid", 1, 0);
      else begin
        e_mon = sbq.pop_front();
        chk("sb_mat_out", mat_out, e_mon.mat);
        chk("sb_mat_size", MW'(mat_size), MW'(e_mon.size));
      end
    end
    mv_prev = mat_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [2:0] sz);
    start = 1'b1; size = sz;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] v, input int gap);
    logic ok;
    ok = 1'b0;
    elem_in = v; elem_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk); ok = elem_ready;
      tick();
      if (ok) break;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    elem_valid = 1'b0;
    repeat (gap) tick();
  endtask

  initial begin
    logic [MW-1:0] exp;
    logic [MW-1:0] exp2;
    int first, vcnt, a0, errs, bhi;
    int bad[3];
    bad = '{1, 6, 7};

    rst = 1'b1; start = 1'b0; size = '0; elem_in = '0; elem_valid = 1'b0; mat_ready = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("rst_mat_out", mat_out, 0);
    chk("rst_mat_size", MW'(mat_size), 0);
    chk("rst_flags", {elem_ready, mat_valid, busy, err}, 0);
    tick();
    rst = 1'b0;

    // 1: size 3, 1..9 back-to-back, consumer already ready
    exp = '0;
    for (int k = 0; k < 9; k++) exp = put(exp, (k/3)*5 + k%3, W'(k+1));
    sbq.push_back('{exp, 3'd3});
    mat_ready = 1'b1; first = -1; vcnt = 0; a0 = acc_cnt;
    for (int cy = 0; cy < 16; cy++) begin
      start = (cy == 0); size = 3'd3;
      elem_valid = (cy >= 1 && cy <= 9); elem_in = W'(cy);
      @(negedge clk);
      if (mat_valid) begin vcnt++; if (first < 0) first = cy; end
      tick();
    end
    start = 1'b0; elem_valid = 1'b0;
    chk("t1_latency", first, 10);
    chk("t1_valid_cycles", vcnt, 1);
    chk("t1_accepted", acc_cnt - a0, 9);
    chk("t1_retained", mat_out, exp);

    // 2: size 2, extreme values with gaps, extra valid after completion
    exp2 = '0;
    exp2 = put(exp2, 0, 8'h80); exp2 = put(exp2, 1, 8'h7F);
    exp2 = put(exp2, 5, 8'hFF); exp2 = put(exp2, 6, 8'h00);
    sbq.push_back('{exp2, 3'd2});
    a0 = acc_cnt;
    do_start(3'd2);
    send(8'h80, 3); send(8'h7F, 3); send(8'hFF, 3); send(8'h00, 3);
    elem_valid = 1'b1; elem_in = 8'h55;
    repeat (4) tick();
    elem_valid = 1'b0;
    chk("t2_accepted", acc_cnt - a0, 4);
    chk("t2_idle", busy, 0);

    // 3: illegal sizes
    foreach (bad[i]) begin
      errs = 0; bhi = 0;
      start = 1'b1; size = 3'(bad[i]);
      for (int cy = 0; cy < 5; cy++) begin
        @(negedge clk);
        errs += int'(err); bhi |= int'(busy);
        tick();
        start = 1'b0;
      end
      chk("t3_err_pulse", errs, 1);
      chk("t3_busy", bhi, 0);
      chk("t3_mat_out", mat_out, exp2);
    end

    // 4: consumer stalls in DONE
    exp = '0;
    exp = put(exp, 0, 8'd1); exp = put(exp, 1, 8'd2); exp = put(exp, 5, 8'd3); exp = put(exp, 6, 8'd4);
    sbq.push_back('{exp, 3'd2});
    mat_ready = 1'b0;
    do_start(3'd2);
    send(8'd1, 0); send(8'd2, 0); send(8'd3, 0); send(8'd4, 0);
    for (int cy = 0; cy < 5; cy++) begin
      @(negedge clk);
      chk("t4_valid_hold", mat_valid, 1);
      chk("t4_mat_hold", mat_out, exp);
      chk("t4_elem_ready", elem_ready, 0);
      tick();
    end
    mat_ready = 1'b1;
    @(negedge clk);
    chk("t4_valid_before_xfer", mat_valid, 1);
    tick();
    @(negedge clk);
    chk("t4_valid_dropped", mat_valid, 0);
    chk("t4_busy", busy, 0);
    chk("t4_retained", mat_out, exp);

    // 5: reset mid-load, then a clean load
    tick();
    do_start(3'd3);
    send(8'd11, 0); send(8'd12, 0); send(8'd13, 0); send(8'd14, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_mat_out", mat_out, 0);
    chk("t5_mat_size", MW'(mat_size), 0);
    chk("t5_flags", {elem_ready, mat_valid, busy, err}, 0);
    tick();
    exp = '0;
    for (int k = 0; k < 9; k++) exp = put(exp, (k/3)*5 + k%3, W'(9-k));
    sbq.push_back('{exp, 3'd3});
    do_start(3'd3);
    for (int k = 0; k < 9; k++) send(W'(9-k), 0);
    for (int t = 0; t < 20 && sbq.size() != 0; t++) tick();

`ifdef MATLOAD_TIMEOUT_EN
    // 6: stall mid-load until the idle timeout fires
    do_start(3'd3);
    send(8'd5, 0); send(8'd6, 0);
    errs = 0;
    for (int t = 0; t < 80; t++) begin
      @(negedge clk);
      errs += int'(err);
      tick();
    end
    chk("t6_err_pulse", errs, 1);
    chk("t6_busy", busy, 0);
    chk("t6_mat_out", mat_out, 0);
`endif

    repeat (3) tick();
    chk("sb_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
